// File: rtl/reg_writeback_unit.sv
// C-bus write side of the register bank: FIFO-buffered commits to GPRs, output ports and Working_Reg.
// Optional forwarding lookup over pending FIFO entries is enabled by defining WB_FWD_EN.
module reg_writeback_unit #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned SEL_W   = 6,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NUM_GPR = 28
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [SEL_W-1:0]  Sel_C,
  input  logic [DATA_W-1:0] Data_C,
  input  logic              C_valid,
  output logic              C_ready,
  input  logic              MW,
  input  logic              MR,
  input  logic [DATA_W-1:0] W_IN,
  output logic              wb_en,
  output logic [4:0]        wb_sel,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] Output_Port_0,
  output logic [DATA_W-1:0] Output_Port_1,
  output logic [DATA_W-1:0] Working_Reg,
  output logic              err_illegal,
  output logic [7:0]        err_count,
  input  logic [SEL_W-1:0]  fwd_sel,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [SEL_W-1:0] SEL_OP0 = SEL_W'(30);
  localparam logic [SEL_W-1:0] SEL_OP1 = SEL_W'(31);
  localparam logic [SEL_W-1:0] SEL_WRK = SEL_W'(34);
  localparam logic [SEL_W-1:0] SEL_GPR_END = SEL_W'(NUM_GPR);

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             rdy_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  entry_t           head;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // Ready is held low through reset and rises on the first edge after release.
  assign C_ready = rdy_q & ~full;
  assign push    = C_valid & C_ready;
  assign pop     = ~empty & ~MW;
  assign head    = mem[rd_ptr];

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= '{sel: Sel_C, data: Data_C};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Commit decode of the head entry
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wb_en         <= 1'b0;
      wb_sel        <= '0;
      wb_data       <= '0;
      Output_Port_0 <= '0;
      Output_Port_1 <= '0;
      Working_Reg   <= '0;
      err_illegal   <= 1'b0;
      err_count     <= '0;
    end else begin
      wb_en       <= 1'b0;
      err_illegal <= 1'b0;
      if (pop) begin
        if (head.sel < SEL_GPR_END) begin
          wb_en   <= 1'b1;
          wb_sel  <= 5'(head.sel);
          wb_data <= head.data;
        end else if (head.sel == SEL_OP0) begin
          Output_Port_0 <= head.data;
        end else if (head.sel == SEL_OP1) begin
          Output_Port_1 <= head.data;
        end else if (head.sel == SEL_WRK) begin
          if (!MR) Working_Reg <= head.data;
        end else begin
          err_illegal <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
      end
      // A memory read wins over a same-edge commit to Working_Reg.
      if (MR) Working_Reg <= W_IN;
    end
  end

`ifdef WB_FWD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Scan oldest to newest so the newest match is the one left standing.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (mem[fwd_idx].sel == fwd_sel)) begin
        fwd_hit  = 1'b1;
        fwd_data = mem[fwd_idx].data;
      end
    end
  end
`else
  logic unused_fwd_sel;

  assign unused_fwd_sel = ^fwd_sel;
  assign fwd_hit        = 1'b0;
  assign fwd_data       = '0;
`endif

endmodule
